key_debounce_multi: RTL and testbench
=====================================

KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 The block SHALL have parameter KEY_NUM, default 4, number of independent key channels (1..32).
REQ-002 The block SHALL have parameter CNT_MAX, default 999999, debounce stable-time terminal count (20 ms at 50 MHz); legal range is 1 or more.
REQ-003 The block SHALL have parameter LONG_MAX, default 49999999, long-press terminal count (1 s at 50 MHz); LONG_MAX SHALL be greater than CNT_MAX.
REQ-004 The block SHALL have parameter CNT_W, default 26, counter width; 2^CNT_W SHALL be greater than LONG_MAX.
REQ-005 The block SHALL have parameter ACTIVE_LOW, default 1; 1 means pressed = 0 at key_in, 0 means pressed = 1.
REQ-006 The block SHALL have port clk_50, input, 1 bit, the single system clock, with all logic on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port key_in, input, KEY_NUM bits, raw asynchronous key levels.
REQ-009 The block SHALL have port key_flag, output, KEY_NUM bits, one-cycle press pulse per channel.
REQ-010 The block SHALL have port key_release, output, KEY_NUM bits, one-cycle release pulse per channel.
REQ-011 The block SHALL have port key_long, output, KEY_NUM bits, one-cycle long-press pulse per channel.
REQ-012 The block SHALL have port key_state, output, KEY_NUM bits, debounced level, 1 = pressed.

Function
REQ-013 Each channel SHALL synchronise key_in through two flops (sync1, sync2) and normalise the level so that 1 = pressed, using ACTIVE_LOW.
REQ-014 Each channel SHALL hold a debounced state (stable) and a debounce counter of width CNT_W.
REQ-015 While sync2 equals stable, the debounce counter SHALL be 0; each cycle sync2 differs from stable, the counter SHALL increment by 1.
REQ-016 On the edge where the counter equals CNT_MAX and sync2 still differs from stable, the block SHALL set stable to sync2 and clear the counter to 0.
REQ-017 On that same edge, the block SHALL assert key_flag for exactly one cycle if stable goes 0 to 1, or key_release for exactly one cycle if stable goes 1 to 0.
REQ-018 If sync2 returns to stable before the counter reaches CNT_MAX, the counter SHALL clear, stable SHALL not change, and the block SHALL produce no pulse.
REQ-019 For a clean level change on key_in that meets setup before edge E1, the stable transition and its pulse SHALL occur at edge E(CNT_MAX+3).
REQ-020 Each channel SHALL have a long counter of width CNT_W that is 0 while stable = 0, increments each cycle while stable = 1, and saturates at LONG_MAX.
REQ-021 key_long SHALL pulse for one cycle on the edge where the long counter goes from LONG_MAX-1 to LONG_MAX, which is LONG_MAX cycles after the key_flag pulse.
REQ-022 key_long SHALL pulse at most once per press; the block SHALL not repeat it while the key is held.
REQ-023 A release SHALL clear the long counter on the edge after stable falls, and a release before LONG_MAX SHALL produce no key_long.
REQ-024 key_state SHALL equal stable with no extra latency.
REQ-025 At most one of key_flag and key_release SHALL be high per channel per cycle, and key_long SHALL never coincide with key_flag.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On rst_n low, asynchronously: sync1, sync2 and stable SHALL take the released value, and all counters SHALL be 0.
REQ-029 On rst_n low, key_flag, key_release, key_long and key_state SHALL be 0.
REQ-030 Reset mid-debounce or mid-hold SHALL discard progress with no pulse emitted.
REQ-031 A key held pressed through reset release SHALL be treated as a new press: key_flag at edge E(CNT_MAX+3) after reset deassertion.

Verification (bench with CNT_MAX=9, LONG_MAX=40, KEY_NUM=4, ACTIVE_LOW=1)
REQ-032 Scenario: key_in[0] falls and is held low -> key_flag[0] high for 1 cycle at edge 12, and key_state[0]=1 from then on.
REQ-033 Scenario: key_in[1] low for 8 cycles and then high, repeated 5 times -> no pulses, and key_state[1] stays 0.
REQ-034 Scenario: key_in[2] held low for 100 cycles and then released -> one key_flag, one key_long 40 cycles later with no repeat, and one key_release 12 cycles after key_in rises.
REQ-035 Scenario: key_in[3] held low for 30 cycles and then released -> key_flag and key_release only, with no key_long.
REQ-036 Scenario: all four keys fall on the same cycle -> key_flag = 4'b1111 for exactly one cycle at edge 12.
REQ-037 Scenario: rst_n pulsed low 5 cycles into debounce with key_in[0] held low -> all outputs 0, and key_flag[0] at edge 12 after rst_n rises.

Source files
------------

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel two-flop sync, counter debounce and press/release/long-press pulses.
module key_debounce_multi #(
  parameter int KEY_NUM    = 4,
  parameter int CNT_MAX    = 999999,
  parameter int LONG_MAX   = 49999999,
  parameter int CNT_W      = 26,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk_50,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_state
);
  localparam logic [KEY_NUM-1:0] REL_RAW = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] LMAX = CNT_W'(LONG_MAX);
  logic [KEY_NUM-1:0] sync1_q, sync2_q, stable_q, stable_d, pressed;
  logic [KEY_NUM-1:0] flag_q, flag_d, rel_q, rel_d, long_q, long_d;
  logic [CNT_W-1:0]   cnt_q [KEY_NUM];
  logic [CNT_W-1:0]   cnt_d [KEY_NUM];
  logic [CNT_W-1:0]   lcnt_q [KEY_NUM];
  logic [CNT_W-1:0]   lcnt_d [KEY_NUM];
  // sync flops hold raw key levels; stable and everything after are 1 = pressed
  assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  always_comb begin
    stable_d = stable_q;
    flag_d   = '0;
    rel_d    = '0;
    long_d   = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      cnt_d[i]    = '0;
      lcnt_d[i]   = '0;
      stable_d[i] = (pressed[i] != stable_q[i] && cnt_q[i] == CMAX) ? pressed[i] : stable_q[i];
      cnt_d[i]    = (pressed[i] != stable_q[i] && cnt_q[i] != CMAX) ? cnt_q[i] + 1'b1 : '0;
      flag_d[i]   = pressed[i] && !stable_q[i] && cnt_q[i] == CMAX;
      rel_d[i]    = !pressed[i] && stable_q[i] && cnt_q[i] == CMAX;
      lcnt_d[i]   = !stable_q[i] ? '0 : (lcnt_q[i] == LMAX ? LMAX : lcnt_q[i] + 1'b1);
      long_d[i]   = stable_q[i] && lcnt_q[i] == LMAX - 1'b1;
    end
  end
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= REL_RAW;
      sync2_q  <= REL_RAW;
      stable_q <= '0;
      flag_q   <= '0;
      rel_q    <= '0;
      long_q   <= '0;
      for (int i = 0; i < KEY_NUM; i++) begin
        cnt_q[i]  <= '0;
        lcnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= key_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      flag_q   <= flag_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
      for (int i = 0; i < KEY_NUM; i++) begin
        cnt_q[i]  <= cnt_d[i];
        lcnt_q[i] <= lcnt_d[i];
      end
    end
  end
  assign key_flag    = flag_q;
  assign key_release = rel_q;
  assign key_long    = long_q;
  assign key_state   = stable_q;
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: directed checks of debounce timing, bounce rejection, long press and reset.
module tb_key_debounce_multi;
  logic       clk_50 = 0;
  logic       rst_n;
  logic [3:0] key_in, key_flag, key_release, key_long, key_state;
  int         compared = 0, mismatched = 0;

  key_debounce_multi #(.KEY_NUM(4), .CNT_MAX(9), .LONG_MAX(40), .CNT_W(26), .ACTIVE_LOW(1)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .key_in(key_in), .key_flag(key_flag),
    .key_release(key_release), .key_long(key_long), .key_state(key_state)
  );

  always #10 clk_50 = ~clk_50;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nf, nr, nl, ef, er, el;
    logic [3:0] seen;
    rst_n  = 0;
    key_in = 4'hF;
    tick(3);
    chk("reset_flag", {28'd0, key_flag}, 0);
    chk("reset_rel", {28'd0, key_release}, 0);
    chk("reset_long", {28'd0, key_long}, 0);
    chk("reset_state", {28'd0, key_state}, 0);
    rst_n = 1;
    tick(5);
    chk("idle_state", {28'd0, key_state}, 0);

    // single press on ch0: flag exactly at edge 12
    key_in[0] = 0;
    tick(11);
    chk("ch0_flag_e11", {28'd0, key_flag}, 0);
    chk("ch0_state_e11", {28'd0, key_state}, 0);
    tick(1);
    chk("ch0_flag_e12", {28'd0, key_flag}, 4'b0001);
    chk("ch0_state_e12", {28'd0, key_state}, 4'b0001);
    tick(1);
    chk("ch0_flag_e13", {28'd0, key_flag}, 0);
    chk("ch0_state_e13", {28'd0, key_state}, 4'b0001);
    key_in[0] = 1;
    tick(11);
    chk("ch0_rel_e11", {28'd0, key_release}, 0);
    tick(1);
    chk("ch0_rel_e12", {28'd0, key_release}, 4'b0001);
    chk("ch0_state_rel", {28'd0, key_state}, 0);
    tick(1);
    chk("ch0_rel_e13", {28'd0, key_release}, 0);
    tick(20);

    // ch1 bounce: 8 cycles low is one short of the debounce window
    seen = 0;
    for (int r = 0; r < 5; r++) begin
      key_in[1] = 0;
      for (int c = 0; c < 8; c++) begin
        tick(1);
        seen |= key_flag | key_release | key_long | key_state;
      end
      key_in[1] = 1;
      for (int c = 0; c < 8; c++) begin
        tick(1);
        seen |= key_flag | key_release | key_long | key_state;
      end
    end
    tick(15);
    seen |= key_flag | key_release | key_long | key_state;
    chk("ch1_bounce_any", {28'd0, seen}, 0);

    // ch2 held 100 cycles: flag@12, long@52 once, release@112
    nf = 0; nr = 0; nl = 0; ef = 0; er = 0; el = 0;
    key_in[2] = 0;
    for (int e = 1; e <= 140; e++) begin
      tick(1);
      if (key_flag[2]) begin nf++; ef = e; end
      if (key_release[2]) begin nr++; er = e; end
      if (key_long[2]) begin nl++; el = e; end
      if (e == 100) key_in[2] = 1;
    end
    chk("ch2_flag_n", nf, 1);
    chk("ch2_flag_edge", ef, 12);
    chk("ch2_long_n", nl, 1);
    chk("ch2_long_edge", el, 52);
    chk("ch2_rel_n", nr, 1);
    chk("ch2_rel_edge", er, 112);

    // ch3 held 30 cycles: no long press
    nf = 0; nr = 0; nl = 0; ef = 0; er = 0;
    key_in[3] = 0;
    for (int e = 1; e <= 80; e++) begin
      tick(1);
      if (key_flag[3]) begin nf++; ef = e; end
      if (key_release[3]) begin nr++; er = e; end
      if (key_long[3]) nl++;
      if (e == 30) key_in[3] = 1;
    end
    chk("ch3_flag_edge", ef, 12);
    chk("ch3_rel_edge", er, 42);
    chk("ch3_counts", {nf[7:0], nr[7:0], nl[7:0]}, {8'd1, 8'd1, 8'd0});

    // all channels together
    key_in = 4'h0;
    tick(11);
    chk("all_flag_e11", {28'd0, key_flag}, 0);
    tick(1);
    chk("all_flag_e12", {28'd0, key_flag}, 4'hF);
    tick(1);
    chk("all_flag_e13", {28'd0, key_flag}, 0);
    chk("all_state", {28'd0, key_state}, 4'hF);
    tick(38);
    chk("all_long_e51", {28'd0, key_long}, 0);
    tick(1);
    chk("all_long_e52", {28'd0, key_long}, 4'hF);
    tick(1);
    chk("all_long_e53", {28'd0, key_long}, 0);
    key_in = 4'hF;
    tick(11);
    chk("all_rel_e11", {28'd0, key_release}, 0);
    tick(1);
    chk("all_rel_e12", {28'd0, key_release}, 4'hF);
    tick(20);

    // reset mid-debounce, key still held through reset release
    key_in[0] = 0;
    tick(5);
    chk("pre_rst_flag", {28'd0, key_flag}, 0);
    rst_n = 0;
    #1;
    chk("rst_outs", {16'd0, key_flag, key_release, key_long, key_state}, 0);
    tick(3);
    chk("rst_hold_outs", {16'd0, key_flag, key_release, key_long, key_state}, 0);
    rst_n = 1;
    tick(11);
    chk("post_rst_e11", {28'd0, key_flag}, 0);
    tick(1);
    chk("post_rst_e12", {28'd0, key_flag}, 4'b0001);
    chk("post_rst_state", {28'd0, key_state}, 4'b0001);
    tick(1);
    chk("post_rst_e13", {28'd0, key_flag}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
